// File: rtl/wb_stage_buf_if.sv
// MEM->WB handshake and register-file write port of the writeback buffer.
// The producer/arbiter side uses master; the buffer itself uses slave.
interface wb_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
);
  localparam int BUS_W = ADDR_W + 1 + 2*DATA_W + PC_W;

  logic [BUS_W-1:0]  mem2wb_bus_i;
  logic              mem_valid_i;
  logic              wb_allowin_o;
  logic              rf_ready_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_wdest_o;
  logic [DATA_W-1:0] rf_wdata_o;

  modport master (
    output mem2wb_bus_i, mem_valid_i, rf_ready_i,
    input  wb_allowin_o, rf_we_o, rf_wdest_o, rf_wdata_o
  );

  modport slave (
    input  mem2wb_bus_i, mem_valid_i, rf_ready_i,
    output wb_allowin_o, rf_we_o, rf_wdest_o, rf_wdata_o
  );
endinterface

// File: rtl/wb_stage_buf.sv
// Writeback stage with a DEPTH-entry in-order retire buffer. The head entry
// drains to the register file when the shared write port grants; all
// buffered writing entries are searched for youngest-match forwarding.
module wb_stage_buf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 64,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_stage_buf_if.slave     wb,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              ctl_wb_over_o,
  output logic [ADDR_W-1:0] ctl_wb_dest_o,
  output logic [PC_W-1:0]   ctl_wb_pc_o,
  output logic [DATA_W-1:0] dbg_dm_addr_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic              empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Field order matches the bus layout: dest is the MSB field.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic              we;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] dm_addr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  entry_t in_ent, head;
  logic   empty, push, pop;

  assign in_ent = entry_t'(wb.mem2wb_bus_i);
  assign head   = ent_q[rptr_q];
  assign empty  = (cnt_q == '0);

  // Handshake, head drain and retire decode; allowin depends on state only.
  always_comb begin
    wb.wb_allowin_o = (cnt_q != FULL_CNT);
    push            = wb.mem_valid_i & wb.wb_allowin_o;
    pop             = !empty & (wb.rf_ready_i | !head.we);
    wb.rf_we_o      = !empty & head.we & wb.rf_ready_i;
    wb.rf_wdest_o   = empty ? '0 : head.dest;
    wb.rf_wdata_o   = empty ? '0 : head.result;
    ctl_wb_over_o   = pop;
    ctl_wb_dest_o   = (!empty && head.we) ? head.dest : '0;
    ctl_wb_pc_o     = empty ? '0 : head.pc;
    dbg_dm_addr_o   = empty ? '0 : head.dm_addr;
    instret_o       = instret_q;
    empty_o         = empty;
  end

  // Next-state: clear the head slot on pop, fill the tail slot on push.
  always_comb begin
    ent_d     = ent_q;
    vld_d     = vld_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    instret_d = instret_q;
    cnt_d     = cnt_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PTR_W'(1);
      instret_d     = instret_q + CNT_W'(1);
    end
    if (push) begin
      ent_d[wptr_q]    = in_ent;
      // Writes to r0 are dropped at entry so they never drain or forward.
      ent_d[wptr_q].we = in_ent.we & !((ZERO_REG != 0) && (in_ent.dest == '0));
      vld_d[wptr_q]    = 1'b1;
      wptr_d           = wptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Forwarding: walk oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if (vld_q[idx] && ent_q[idx].we && (ent_q[idx].dest == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = ent_q[idx].result;
      end
    end
    if ((ZERO_REG != 0) && (fwd_addr_i == '0)) begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
    end
  end

  // State registers; reset discards buffered entries without writing them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      vld_q     <= vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed scenarios plus random traffic, all
// checked against a queue-based model of the retire buffer.
module tb_wb_stage_buf;
  localparam int DATA_W = 32, ADDR_W = 5, PC_W = 32, DEPTH = 4, CNT_W = 64;
  localparam int ZERO_REG = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [ADDR_W-1:0] fwd_addr;
  logic fwd_hit, wb_over, empty;
  logic [DATA_W-1:0] fwd_data, dm_addr;
  logic [ADDR_W-1:0] wb_dest;
  logic [PC_W-1:0] wb_pc;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  wb_stage_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) mif();

  wb_stage_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH),
                 .CNT_W(CNT_W), .ZERO_REG(ZERO_REG)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(mif.slave), .fwd_addr_i(fwd_addr),
    .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data), .ctl_wb_over_o(wb_over),
    .ctl_wb_dest_o(wb_dest), .ctl_wb_pc_o(wb_pc), .dbg_dm_addr_o(dm_addr),
    .instret_o(instret), .empty_o(empty));

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic              we;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] dma;
    logic [PC_W-1:0]   pc;
  } ent_t;

  ent_t q[$];
  logic [CNT_W-1:0] m_instret = '0;
  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check every output against the model,
  // then advance the model across the posedge.
  task automatic step(input logic v, input logic [ADDR_W-1:0] d, input logic we,
                      input logic [DATA_W-1:0] r, input logic [PC_W-1:0] pc,
                      input logic rdy, input logic [ADDR_W-1:0] fa);
    logic [DATA_W-1:0] dma;
    logic e_hit, e_allow, e_empty, do_push, do_pop;
    logic [DATA_W-1:0] e_fdata;
    ent_t n;
    dma = $urandom;
    @(negedge clk);
    mif.mem_valid_i  = v;
    mif.mem2wb_bus_i = {d, we, r, dma, pc};
    mif.rf_ready_i   = rdy;
    fwd_addr         = fa;
    #1;
    e_empty = (q.size() == 0);
    e_allow = (q.size() != DEPTH);
    e_hit = 1'b0; e_fdata = '0;
    if (!(ZERO_REG != 0 && fa == 0))
      foreach (q[i]) if (q[i].we && q[i].dest == fa) begin e_hit = 1'b1; e_fdata = q[i].res; end
    do_push = v && e_allow;
    do_pop  = !e_empty && (rdy || !q[0].we);
    chk("allowin", mif.wb_allowin_o, e_allow);
    chk("empty",   empty, e_empty);
    chk("fwd_hit", fwd_hit, e_hit);
    chk("fwd_data", fwd_data, e_fdata);
    chk("wb_over", wb_over, do_pop);
    chk("instret", instret, m_instret);
    chk("rf_we",    mif.rf_we_o,    !e_empty && q[0].we && rdy);
    chk("rf_wdest", mif.rf_wdest_o, e_empty ? '0 : q[0].dest);
    chk("rf_wdata", mif.rf_wdata_o, e_empty ? '0 : q[0].res);
    chk("wb_dest",  wb_dest, (!e_empty && q[0].we) ? q[0].dest : '0);
    chk("wb_pc",    wb_pc,   e_empty ? '0 : q[0].pc);
    chk("dm_addr",  dm_addr, e_empty ? '0 : q[0].dma);
    @(posedge clk);
    if (do_pop) begin void'(q.pop_front()); m_instret++; end
    if (do_push) begin
      n.dest = d; n.we = we && !(ZERO_REG != 0 && d == 0); n.res = r; n.dma = dma; n.pc = pc;
      q.push_back(n);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, '0, '0, rdy, '0);
  endtask

  // Asynchronous reset with a check taken before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    mif.mem_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_empty",   empty, 1'b1);
    chk("rst_allowin", mif.wb_allowin_o, 1'b1);
    chk("rst_rf_we",   mif.rf_we_o, 1'b0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_wb_pc",   wb_pc, 32'd0);
    q.delete();
    m_instret = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mif.mem_valid_i = 1'b0; mif.mem2wb_bus_i = '0; mif.rf_ready_i = 1'b0; fwd_addr = '0;
    #12 rst_n = 1'b1;

    // Reset mid-stream: three entries buffered, then reset without an edge.
    for (int i = 0; i < 3; i++) step(1'b1, ADDR_W'(i + 1), 1'b1, 32'h100 + i, 32'h1000 + 4*i, 1'b0, '0);
    do_reset();

    // Single pass.
    step(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 32'h1C000000, 1'b1, '0);
    chk("pass_rf_we", mif.rf_we_o, 1'b1);
    chk("pass_wdata", mif.rf_wdata_o, 32'hDEADBEEF);
    idle(1'b1);
    chk("pass_instret", instret, 64'd1);

    // Zero-register and non-writing entries retire without a grant.
    step(1'b1, 5'd0, 1'b1, 32'h55, 32'h2000, 1'b0, '0);
    idle(1'b0);
    step(1'b1, 5'd9, 1'b0, 32'h66, 32'h2004, 1'b0, 5'd9);
    idle(1'b0);
    chk("zr_instret", instret, 64'd3);

    // Forward priority: younger r7 wins, r0 never hits.
    step(1'b1, 5'd7, 1'b1, 32'h11, 32'h3000, 1'b0, '0);
    step(1'b1, 5'd7, 1'b1, 32'h22, 32'h3004, 1'b0, '0);
    fwd_addr = 5'd7; #1;
    chk("fwd_young_hit", fwd_hit, 1'b1);
    chk("fwd_young_data", fwd_data, 32'h22);
    fwd_addr = 5'd0; #1;
    chk("fwd_r0", fwd_hit, 1'b0);
    step(1'b1, 5'd3, 1'b1, 32'h33, 32'h3008, 1'b0, 5'd7);
    step(1'b1, 5'd4, 1'b1, 32'h44, 32'h300C, 1'b0, 5'd3);
    chk("full_allowin", mif.wb_allowin_o, 1'b0);
    step(1'b1, 5'd6, 1'b1, 32'h77, 32'h3010, 1'b0, 5'd7); // blocked
    step(1'b1, 5'd6, 1'b1, 32'h78, 32'h3014, 1'b1, 5'd7); // pop while full: push still blocked
    chk("after_pop_allowin", mif.wb_allowin_o, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Back-to-back stream with simultaneous push/pop and pointer wrap.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, ADDR_W'(i + 1), 1'b1, 32'hA0 + i, 32'h4000 + 4*i, 1'b1, ADDR_W'(i));
    idle(1'b1);
    chk("stream_instret", instret, 64'd10);
    chk("stream_empty", empty, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
           $urandom, $urandom, $urandom_range(0, 2) == 0, ADDR_W'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
